// File: rtl/edp_fm.sv
// edp_fm: EDP fast-memory (AC file), 8 blocks x 16 ACs x 36 bits.
// Each half-word carries its own odd parity bit. The block owns the power-up
// clear sweep, per-half write-first forwarding, parity checking and capture
// of the address of the first parity error.
module edp_fm #(
    parameter int BLOCKS = 8,
    parameter int WORDS  = 128,
    localparam int BW    = $clog2(BLOCKS),
    localparam int AW    = BW + 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [0:BW-1] fmBlk,
    input  logic [0:3]    fmAdr,
    input  logic          fmWrite00_17,
    input  logic          fmWrite18_35,
    input  logic [0:35]   EDP_AR,
    input  logic          fmBadParity,
    input  logic          fmParityChk,
    input  logic          fmErrClr,
    output logic [0:35]   FM,
    output logic          fmParity,
    output logic          fmParityErr,
    output logic [0:AW-1] fmErrAdr,
    output logic          fmInitBusy,
    output logic          fmWrite
);

    typedef enum logic [1:0] {ST_RESET, ST_SWEEP, ST_RUN} state_t;

    // Storage: each half is kept with its stored parity bit.
    logic [0:17] mem_l [WORDS];
    logic [0:17] mem_r [WORDS];
    logic        mem_pl [WORDS];
    logic        mem_pr [WORDS];

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_adr_q, rd_adr_d;
    logic          err_q, err_d;
    logic [AW-1:0] err_adr_q, err_adr_d;

    logic          sweep, run, busy;
    logic          we_l, we_r, wp_l, wp_r;
    logic [0:17]   wd_l, wd_r;
    logic [AW-1:0] wr_adr;
    logic          bad_l, bad_r, err_set;

    // Init sequencer: RESET holds the counter at 0; the sweep starts on the
    // first cycle reset is low, so the clear takes exactly WORDS clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sweep   = 1'b0;
        case (state_q)
            ST_RESET, ST_SWEEP: begin
                if (!reset) begin
                    sweep = 1'b1;
                    if (cnt_q == AW'(WORDS - 1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SWEEP;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (reset) begin
            state_d = ST_RESET;
            cnt_d   = '0;
        end
    end

    // Write port: sweep writes a cleared word with good parity; external
    // writes are honoured only in RUN. Bad-parity only affects halves written.
    always_comb begin
        busy    = (state_q != ST_RUN);
        run     = !busy && !reset;
        we_l    = sweep | (run & fmWrite00_17);
        we_r    = sweep | (run & fmWrite18_35);
        wr_adr  = sweep ? cnt_q : {fmBlk, fmAdr};
        wd_l    = sweep ? 18'b0 : EDP_AR[0:17];
        wd_r    = sweep ? 18'b0 : EDP_AR[18:35];
        wp_l    = ~(^wd_l) ^ (run & fmBadParity);
        wp_r    = ~(^wd_r) ^ (run & fmBadParity);
        fmWrite = we_l | we_r;
    end

    // Array update; no reset on storage, the sweep clears it.
    always_ff @(posedge clk) begin
        if (we_l) begin
            mem_l[wr_adr]  <= wd_l;
            mem_pl[wr_adr] <= wp_l;
        end
        if (we_r) begin
            mem_r[wr_adr]  <= wd_r;
            mem_pr[wr_adr] <= wp_r;
        end
    end

    // Read path: registered address, array read after the edge, so a write
    // to the sampled address is seen immediately (write-first per half).
    always_comb begin
        rd_adr_d = {fmBlk, fmAdr};
        FM       = busy ? 36'b0 : {mem_l[rd_adr_q], mem_r[rd_adr_q]};
        fmParity = ^FM;
    end

    // Parity check and sticky first-error capture; clear beats a new set.
    always_comb begin
        bad_l     = ~((^FM[0:17]) ^ mem_pl[rd_adr_q]);
        bad_r     = ~((^FM[18:35]) ^ mem_pr[rd_adr_q]);
        err_set   = fmParityChk & ~busy & (bad_l | bad_r);
        err_d     = err_q;
        err_adr_d = err_adr_q;
        if (fmErrClr) begin
            err_d     = 1'b0;
            err_adr_d = '0;
        end else if (err_set) begin
            err_d = 1'b1;
            if (!err_q) err_adr_d = rd_adr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        rd_adr_q <= rd_adr_d;
        if (reset) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign fmParityErr = err_q;
    assign fmErrAdr    = err_adr_q;
    assign fmInitBusy  = busy;

endmodule
